// File: rtl/stream_packer_if.sv
// stream_packer_if: 32-bit beat input stream and packed 64-bit word output stream
interface stream_packer_if #(parameter int DATA_W = 32);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] out_data;
  logic [1:0]          out_keep;
  logic                out_last;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/stream_packer.sv
// stream_packer: packs beat pairs into double-width words with half keep flags and packet count
module stream_packer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_packer_if.slave   bus,
  output logic [CNT_W-1:0] pkt_count
);
  logic [DATA_W-1:0] lo_q;
  logic              have_lo;
  logic              acc;
  logic              xfer;
  logic              complete;
  assign bus.in_ready = rst_n && (!bus.out_valid || bus.out_ready);
  assign acc          = bus.in_valid && bus.in_ready;
  assign xfer         = bus.out_valid && bus.out_ready;
  assign complete     = acc && (have_lo || bus.in_last);
  // Hold the first beat of a pair until its partner arrives; a lone last beat bypasses it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lo_q    <= '0;
      have_lo <= 1'b0;
    end else if (acc) begin
      have_lo <= !have_lo && !bus.in_last;
      if (!have_lo && !bus.in_last) lo_q <= bus.in_data;
    end
  // Output word register: load on a completing beat, otherwise drop valid once consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_keep  <= 2'b00;
      bus.out_last  <= 1'b0;
    end else if (complete) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= have_lo ? {bus.in_data, lo_q} : {{DATA_W{1'b0}}, bus.in_data};
      bus.out_keep  <= have_lo ? 2'b11 : 2'b01;
      bus.out_last  <= bus.in_last;
    end else if (xfer) begin
      bus.out_valid <= 1'b0;
    end
  // Count packet-ending words as they leave, wrapping naturally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pkt_count <= '0;
    else if (xfer && bus.out_last) pkt_count <= pkt_count + 1'b1;
endmodule

// File: tb/tb_stream_packer.sv
// tb_stream_packer: scoreboard bench with a queue-based packing model for stream_packer
module tb_stream_packer;
  localparam int DW = 32;
  localparam int CW = 2;
  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  keep;
    logic        last;
  } word_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CW-1:0] pkt_count;
  int            checks = 0;
  int            errors = 0;
  word_t         exp_q[$];
  logic [31:0]   pend[$];
  logic [CW-1:0] exp_cnt = '0;
  logic          hold_v = 1'b0;
  word_t         hold_w;
  logic          done = 1'b0;

  stream_packer_if #(.DATA_W(DW)) bus();
  stream_packer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int  n;
    logic a;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    do begin
      @(negedge clk);
      a = bus.in_ready;
      tick();
      n++;
    end while (!a && n < 200);
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %h not accepted, required acceptance", d);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_model();
    pend.delete();
    exp_q.delete();
    exp_cnt = '0;
  endtask

  // Reference model: collect accepted beats, emit a word per pair or at packet end
  always @(negedge clk)
    if (rst_n && bus.in_valid && bus.in_ready) begin
      word_t w;
      pend.push_back(bus.in_data);
      if (pend.size() == 2 || bus.in_last) begin
        if (pend.size() == 2) begin
          w.data = {pend[1], pend[0]};
          w.keep = 2'b11;
        end else begin
          w.data = {32'h0, pend[0]};
          w.keep = 2'b01;
        end
        w.last = bus.in_last;
        exp_q.push_back(w);
        pend.delete();
      end
    end

  // Monitor: check stall stability and compare every transferred word with the model
  always @(negedge clk)
    if (!rst_n) hold_v = 1'b0;
    else begin
      word_t cur;
      word_t e;
      cur = {bus.out_data, bus.out_keep, bus.out_last};
      if (hold_v) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_word", cur, hold_w);
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_w = cur;
      if (hold_v) chk("stall_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("pkt_count", pkt_count, exp_cnt);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected no word", cur);
        end else begin
          e = exp_q.pop_front();
          chk("word", cur, e);
          if (e.last) exp_cnt++;
        end
      end
    end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_keep", bus.out_keep, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", bus.in_ready, 1);
    tick();
    bus.out_ready = 1'b1;
    send(32'h0000AAAA, 1'b0);
    send(32'h0000BBBB, 1'b0);
    @(negedge clk);
    chk("pair_valid", bus.out_valid, 1);
    chk("pair_data", bus.out_data, 64'h0000BBBB_0000AAAA);
    chk("pair_keep", bus.out_keep, 2'b11);
    chk("pair_last", bus.out_last, 0);
    tick();
    @(negedge clk);
    chk("pair_one_cycle", bus.out_valid, 0);
    tick();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
      end
      begin
        repeat (6) tick();
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) tick();
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    @(negedge clk);
    chk("odd_data", bus.out_data, 64'h0000_0000_0000_0003);
    chk("odd_keep", bus.out_keep, 2'b01);
    chk("odd_last", bus.out_last, 1);
    tick();
    @(negedge clk);
    chk("odd_pkt_count", pkt_count, 1);
    tick();
    send(32'h0000DEAD, 1'b0);
    rst_n = 1'b0;
    reset_model();
    repeat (2) tick();
    rst_n = 1'b1;
    send(32'h00001111, 1'b0);
    send(32'h00002222, 1'b0);
    @(negedge clk);
    chk("midrst_data", bus.out_data, 64'h00002222_00001111);
    chk("midrst_keep", bus.out_keep, 2'b11);
    tick();
    for (int i = 0; i < 4; i++) begin
      send($urandom, 1'b0);
      send($urandom, 1'b1);
      tick();
      @(negedge clk);
      chk("wrap_pkt_count", pkt_count, 67'((i + 1) % 4));
      tick();
    end
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          send($urandom, $urandom_range(0, 4) == 0);
        end
        send($urandom, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = $urandom_range(0, 3) != 0;
          tick();
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("drain_words", 67'(exp_q.size()), 0);
    chk("drain_partial", 67'(pend.size()), 0);
    chk("final_pkt_count", pkt_count, exp_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_packer.md
# stream_packer

Downstream consumer of the 32-bit valid/ready pipeline register stage. It packs pairs of input beats into one 64-bit output word, with byte-lane-style half-word keep flags and packet-end marking, and exposes a wrapping count of completed packets. Both sides use the same valid/ready handshake, and the block sustains full throughput on the input side when the output side is not stalled.

## Interface
- DATA_W, default 32: input beat width; output width is 2*DATA_W.
- CNT_W, default 16: width of the packet counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low (one clock; async active-low reset).
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  DATA_W  upstream beat.
- in_last  input  1  beat is the final beat of a packet; tie 0 if packets are unused.
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accepts the packed word.
- out_data  output  2*DATA_W  packed word; the first-accepted beat is in the low half.
- out_keep  output  2  bit0 = low half valid, bit1 = high half valid.
- out_last  output  1  word ends a packet.
- pkt_count  output  CNT_W  number of out_last words handshaken, modulo 2^CNT_W.

## Operation
- State:
  - lo_q (DATA_W) and have_lo flag: pending low half.
  - Output register: out_data, out_keep, out_last, out_valid.
  - pkt_count.
- Handshakes:
  - Input accept: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- in_ready = rst_n && (!out_valid || out_ready). It is combinational from out_ready and registered state, with no path from in_valid.
- On input accept:
  - have_lo=0, in_last=0: lo_q <= in_data, have_lo <= 1. Output register unchanged, except that out_valid clears if a transfer occurs this cycle.
  - have_lo=0, in_last=1: load out_data={0, in_data}, out_keep=2'b01, out_last=1, out_valid=1.
  - have_lo=1: load out_data={in_data, lo_q}, out_keep=2'b11, out_last=in_last, out_valid=1, have_lo <= 0.
- No input accept and an output transfer occurs: out_valid <= 0. out_data, out_keep and out_last hold their last values.
- pkt_count increments by 1 on each output transfer with out_last=1, and wraps from all-ones to 0.
- Stall: while out_valid && !out_ready, out_data, out_keep and out_last are stable, and in_ready=0. This holds even when have_lo=0.
- Simultaneous output transfer and a completing input accept: the new word replaces the old one in the same edge, and out_valid stays 1 (back-to-back).
- A partial low half (have_lo=1) is retained indefinitely until its partner beat arrives. There is no timeout.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - out_valid=0, out_data=0, out_keep=0, out_last=0, pkt_count=0, have_lo=0, lo_q=0.
  - in_ready=0.
- First cycle after rst_n rises: in_ready=1.
- Latency: a packed word is visible with out_valid=1 on the clock edge that accepts its completing beat, which is 1 cycle after that beat is presented with in_ready=1.
- Throughput: with out_ready held at 1, one input beat is accepted every cycle, giving one output word every 2 cycles (every cycle for single-beat last packets).
- Reset mid-operation: a pending lo_q and any held output word are discarded. Post-reset beats pack from the low half.
- The inputs in_data and in_last are sampled only on input accept. Values presented while not accepted are ignored.

## Test plan
- Reset: rst_n=0 for 2 cycles → all outputs 0 and in_ready=0; one cycle after release → in_ready=1.
- Pair pack: out_ready=1; beats 0x0000AAAA then 0x0000BBBB, in_last=0 → one word 0x0000BBBB_0000AAAA, out_keep=11, out_last=0, out_valid high for one cycle.
- Stall: out_ready=0; present beats 1,2,3,4 continuously → word {2,1} held stable, in_ready=0 after 2nd accept. Raise out_ready → words {2,1} then {4,3} in order, no loss or duplication.
- Odd packet: beats 1,2,3 with in_last on 3 → {2,1} keep=11 last=0, then {0,3} keep=01 last=1; pkt_count=1.
- Even packet end plus wrap: CNT_W=2, four packets of 2 beats each, last on every 2nd beat → each word keep=11 last=1; pkt_count goes 1,2,3,0.
- Reset mid-pair: accept beat 0xDEAD, pulse rst_n low, then send 0x1111, 0x2222 → single word 0x00002222_00001111; 0xDEAD never appears.
